if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage core (IF→ID→EX→IO→WB).
- Owns the program counter and issues one instruction-SRAM request at a time over a req/addr_ok/data_ok handshake.
- Holds the returned instruction until ID accepts it, then presents it to ID as IFToIDInstructionBusData.
- Applies branch redirects from ID (IDToIFBranchBusData) with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC of the first fetch after reset.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_allow_in  in  1  ID can accept an instruction this cycle.
- branch_bus  in  33  IDToIFBranchBusData {taken, target}.
- if_to_id_bus  out  65  IFToIDInstructionBusData {valid, program_count, instruction}.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  32  fetch address (word aligned).
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  32  read data.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values:
  - state=REQ, pc=RESET_PC, br_pending=0, br_target=0.
  - inst_buf=0, if_to_id_bus=0 (valid=0).
  - inst_sram_req forced 0 while reset_n=0.
- States (FetchState): REQ, WAIT, HOLD.
  - REQ: inst_sram_req=1, inst_sram_addr=pc. addr_ok=1 → WAIT. Otherwise stay, holding req and addr stable.
  - WAIT: req=0. data_ok=1 → inst_buf<=rdata, go to HOLD.
  - HOLD: if_to_id_bus.valid=1, program_count=pc, instruction=inst_buf.
- Fire = HOLD && id_allow_in.
  - On fire: pc<=next_pc, br_pending<=0, state<=REQ.
  - No fire: hold all outputs stable.
- next_pc = taken ? branch_bus.target : (br_pending ? br_target : pc+4). Arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Branch capture:
  - branch_bus.taken=1 in any state without fire → br_pending<=1, br_target<=target.
  - A later taken overwrites the latched target (ID re-presents the same branch while stalled).
  - taken coincident with fire → uses the live target; nothing is latched.
- Delay slot: the instruction in IF while ID holds a taken branch is the delay slot. It is never cancelled. The redirect applies only to the fetch after it.
- Throughput: at most one outstanding request. Minimum 3 cycles per instruction (REQ, WAIT, HOLD); fire in HOLD re-enters REQ next cycle.
- data_ok in REQ or HOLD is ignored (covers a stale response after a mid-fetch reset). addr_ok outside REQ is ignored.
- Reset mid-operation: immediate return to reset values. The outstanding SRAM transaction is abandoned and its data_ok discarded per the rule above.
- Misaligned targets are not checked; pc[1:0] is passed through unchanged.

Decomposition:
- Add to if_stage_params:
  - FetchState enum (2-bit: REQ, WAIT, HOLD).
  - RESET_PC default constant.
  - Existing IFToIDInstructionBusData (already defined there).
- Import IDToIFBranchBusData from id_stage_params.
- One combinational sub-module, if_next_pc_select: inputs pc, branch_bus, br_pending, br_target; output next_pc.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release. Next cycle req=1, addr=BFC0_0000; if_to_id_bus.valid=0 throughout reset.
- Straight-line: addr_ok, then data_ok with 0x2402_0001, id_allow_in=1. ID sees {1, BFC0_0000, 24020001}; next req addr=BFC0_0004.
- ID stall: id_allow_in=0 for 5 cycles in HOLD. Bus stays stable, req=0. After release, one fire occurs and addr=pc+4.
- Branch with delay slot:
  - ID asserts taken, target=BFC0_0100 while IF is in WAIT for BFC0_0008. BFC0_0008 is still delivered.
  - The following request is BFC0_0100; br_pending=0 afterwards.
  - Repeat with taken coincident with fire: same result.
- Slow SRAM: addr_ok withheld for 4 cycles. req/addr stay stable; only one transaction is issued.
- Mid-fetch reset: pulse reset_n low in WAIT, then data_ok arrives in the first cycle after release. The data is ignored; req=1, addr=BFC0_0000; valid=0.
- Wrap: pc=FFFF_FFFC fires with no branch → next addr=0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types for the fetch stage.
// id_stage_params carries the branch bus that ID drives back into IF.
// if_stage_params carries the fetch FSM encoding, the reset PC and the IF->ID bus.

package id_stage_params;

    // Redirect request from ID. The taken flag qualifies target.
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } IDToIFBranchBusData;

endpackage : id_stage_params

package if_stage_params;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Fetch FSM: issue request, wait for data, hold for ID.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } FetchState;

    // Instruction handed to ID. The valid flag qualifies the other fields.
    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] instruction;
    } IFToIDInstructionBusData;

    // Sequential successor. Wraps modulo 2^32 and keeps pc[1:0] untouched.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : if_stage_params

// File: rtl/if_stage_next_pc_select.sv
// Next-PC selection for the fetch stage.
// A live taken branch wins, then a latched redirect, then the sequential PC.

module if_next_pc_select
    import id_stage_params::*;
    import if_stage_params::*;
(
    input  logic [31:0]        i_pc,
    input  IDToIFBranchBusData i_branch_bus,
    input  logic               i_br_pending,
    input  logic [31:0]        i_br_target,
    output logic [31:0]        o_next_pc
);

    // Priority mux for the address of the fetch after the current one.
    always_comb begin
        // NOTE: a default on entry to every always_comb keeps every path assigned, so no latch is inferred.
        o_next_pc = pc_plus4(i_pc);
        if (i_branch_bus.taken) begin
            o_next_pc = i_branch_bus.target;
        end else if (i_br_pending) begin
            o_next_pc = i_br_target;
        end
    end

endmodule : if_next_pc_select

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and runs one SRAM fetch at a time.
// The fetched word is held until ID takes it. A branch seen while the delay
// slot is still in IF is remembered and steers the fetch after the slot.

module if_stage
    import id_stage_params::*;
    import if_stage_params::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    id_allow_in,
    input  IDToIFBranchBusData      branch_bus,
    output IFToIDInstructionBusData if_to_id_bus,
    output logic                    inst_sram_req,
    output logic [31:0]             inst_sram_addr,
    input  logic                    inst_sram_addr_ok,
    input  logic                    inst_sram_data_ok,
    input  logic [31:0]             inst_sram_rdata
);

    FetchState   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst_buf;
    logic        r_br_pending;
    logic [31:0] r_br_target;

    logic        w_fire;
    logic [31:0] w_next_pc;

    // ID takes the held instruction.
    assign w_fire = (r_state == HOLD) && id_allow_in;

    if_next_pc_select u_next_pc_select (
        .i_pc         (r_pc),
        .i_branch_bus (branch_bus),
        .i_br_pending (r_br_pending),
        .i_br_target  (r_br_target),
        .o_next_pc    (w_next_pc)
    );

    // Fetch FSM: REQ until the address is accepted, WAIT for data, HOLD until ID fires.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_inst_buf <= 32'd0;
        end else begin
            // NOTE: state registers use <= so every flop samples pre-edge values, independent of statement order.
            case (r_state)
                REQ: begin
                    if (inst_sram_addr_ok) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (inst_sram_data_ok) begin
                        r_inst_buf <= inst_sram_rdata;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_fire) begin
                        r_pc    <= w_next_pc;
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

    // Remember a taken branch until the delay slot leaves IF; a repeat overwrites it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_br_pending <= 1'b0;
            r_br_target  <= 32'd0;
        end else if (w_fire) begin
            r_br_pending <= 1'b0;
        end else if (branch_bus.taken) begin
            r_br_pending <= 1'b1;
            r_br_target  <= branch_bus.target;
        end
    end

    // SRAM request decoded from state; held low while reset is asserted.
    assign inst_sram_req  = reset_n && (r_state == REQ);
    assign inst_sram_addr = r_pc;

    // Present the held instruction only in HOLD; the bus is all-zero otherwise.
    always_comb begin
        if_to_id_bus = '0;
        if (r_state == HOLD) begin
            if_to_id_bus.valid         = 1'b1;
            if_to_id_bus.program_count = r_pc;
            if_to_id_bus.instruction   = r_inst_buf;
        end
    end

endmodule : if_stage
